chacha_block_core: RTL and testbench

- Self-sequencing ChaCha block-function engine: byte-wide load of a 16x32-bit input state, then on `start` runs a configurable number of double rounds using one quarter-round unit per cycle.
- Optionally adds the input state back in (feed-forward) and auto-increments the block counter word.
- Successor to the externally driven quarter-round state holder: round scheduling, the QR datapath and counter handling are all internal.
- Sits between the byte-wide pin interface and the keystream consumer.

---
 rtl/chacha_pkg.sv | 45 ++++
 rtl/chacha_qr.sv | 33 +++
 rtl/chacha_block_core.sv | 97 +++++++++
 tb/tb_chacha_block_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and the quarter-round word selection for the ChaCha core.
package chacha_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } qr_sel_t;

  localparam int unsigned ROT_1 = 16;
  localparam int unsigned ROT_2 = 12;
  localparam int unsigned ROT_3 = 8;
  localparam int unsigned ROT_4 = 7;

  localparam word_t SIGMA_0 = 32'h61707865;
  localparam word_t SIGMA_1 = 32'h3320646e;
  localparam word_t SIGMA_2 = 32'h79622d32;
  localparam word_t SIGMA_3 = 32'h6b206574;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // qr_idx[2] picks column/diagonal; 2-bit lane arithmetic gives the mod-4 wrap for free.
  function automatic qr_sel_t qr_map(input logic [2:0] idx);
    qr_sel_t    s;
    logic [1:0] lane, l1, l2, l3;
    lane = idx[1:0];
    l1   = idx[2] ? lane + 2'd1 : lane;
    l2   = idx[2] ? lane + 2'd2 : lane;
    l3   = idx[2] ? lane + 2'd3 : lane;
    s.a  = {2'b00, lane};
    s.b  = {2'b01, l1};
    s.c  = {2'b10, l2};
    s.d  = {2'b11, l3};
    return s;
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Purely combinational ChaCha quarter-round.
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_out,
  output word_t b_out,
  output word_t c_out,
  output word_t d_out
);

  word_t a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    a1 = a + b;
    d1 = rotl(d ^ a1, ROT_1);
    c1 = c + d1;
    b1 = rotl(b ^ c1, ROT_2);
    a2 = a1 + b1;
    d2 = rotl(d1 ^ a2, ROT_3);
    c2 = c1 + d2;
    b2 = rotl(b1 ^ c2, ROT_4);
  end

  assign a_out = a2;
  assign b_out = b2;
  assign c_out = c2;
  assign d_out = d2;

endmodule

// File: rtl/chacha_block_core.sv
// ChaCha block engine: byte-loaded input state, one quarter-round per cycle,
// optional feed-forward and block-counter increment.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10,
  parameter bit FEED_FORWARD  = 1'b1,
  parameter bit COUNTER_INC   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       start,
  output logic       busy,
  output logic       done
);

  state_t     init, work;
  fsm_t       state, state_nxt;
  logic [2:0] qr_idx;
  logic [3:0] rnd;
  logic       last_qr;
  qr_sel_t    sel;
  word_t      qa, qb, qc, qd;

  assign sel     = qr_map(qr_idx);
  assign last_qr = (qr_idx == 3'd7) && (rnd == 4'(DOUBLE_ROUNDS - 1));
  assign busy    = (state != IDLE);
  assign rd_data = work[rd_addr[5:2]][{rd_addr[1:0], 3'b000} +: 8];

  chacha_qr u_qr (
    .a     (work[sel.a]),
    .b     (work[sel.b]),
    .c     (work[sel.c]),
    .d     (work[sel.d]),
    .a_out (qa),
    .b_out (qb),
    .c_out (qc),
    .d_out (qd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUND;
      ROUND:   if (last_qr) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      init   <= '0;
      work   <= '0;
      qr_idx <= '0;
      rnd    <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINAL);
      case (state)
        IDLE: begin
          // start takes priority; a coincident write is dropped
          if (start) begin
            work   <= init;
            qr_idx <= '0;
            rnd    <= '0;
          end else if (wr_en) begin
            init[wr_addr[5:2]][{wr_addr[1:0], 3'b000} +: 8] <= wr_data;
          end
        end
        ROUND: begin
          work[sel.a] <= qa;
          work[sel.b] <= qb;
          work[sel.c] <= qc;
          work[sel.d] <= qd;
          qr_idx      <= qr_idx + 3'd1;
          if (qr_idx == 3'd7) rnd <= rnd + 4'd1;
        end
        FINAL: begin
          if (FEED_FORWARD) begin
            for (int k = 0; k < 16; k++) work[k] <= work[k] + init[k];
          end
          if (COUNTER_INC) init[12] <= init[12] + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_core.sv
// Scoreboarded bench: a software ChaCha model predicts each block when start is driven.
module tb_chacha_block_core;
  import chacha_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, start = 1'b0, sel = 1'b0;
  logic [5:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data1, rd_data2, rdd;
  logic       busy1, busy2, done1, done2, busy_s, done_s;

  always #5 clk = ~clk;

  chacha_block_core u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1), .start(start & ~sel), .busy(busy1), .done(done1)
  );

  chacha_block_core #(.DOUBLE_ROUNDS(4), .FEED_FORWARD(1'b0), .COUNTER_INC(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en & sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data2), .start(start & sel), .busy(busy2), .done(done2)
  );

  word_t qa_o, qb_o, qc_o, qd_o;
  chacha_qr u_qr (
    .a(32'h11111111), .b(32'h01020304), .c(32'h9b8d6f43), .d(32'h01234567),
    .a_out(qa_o), .b_out(qb_o), .c_out(qc_o), .d_out(qd_o)
  );

  assign rdd    = sel ? rd_data2 : rd_data1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;

  int     errors = 0, checks = 0;
  state_t sh [2];
  state_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic word_t rl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic state_t qrs(input state_t s, input int a, input int b, input int c, input int d);
    s[a] += s[b]; s[d] = rl(s[d] ^ s[a], 16);
    s[c] += s[d]; s[b] = rl(s[b] ^ s[c], 12);
    s[a] += s[b]; s[d] = rl(s[d] ^ s[a], 8);
    s[c] += s[d]; s[b] = rl(s[b] ^ s[c], 7);
    return s;
  endfunction

  function automatic state_t model(input state_t in, input int dr, input bit ff);
    state_t x = in;
    for (int r = 0; r < dr; r++) begin
      x = qrs(x, 0, 4, 8, 12); x = qrs(x, 1, 5, 9, 13);
      x = qrs(x, 2, 6, 10, 14); x = qrs(x, 3, 7, 11, 15);
      x = qrs(x, 0, 5, 10, 15); x = qrs(x, 1, 6, 11, 12);
      x = qrs(x, 2, 7, 8, 13); x = qrs(x, 3, 4, 9, 14);
    end
    if (ff) for (int k = 0; k < 16; k++) x[k] += in[k];
    return x;
  endfunction

  task automatic write_word(input int k, input word_t w);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 6'(k * 4 + b); wr_data = w[8*b +: 8];
    end
    @(negedge clk);
    wr_en = 1'b0;
    sh[sel][k] = w;
  endtask

  task automatic read_word(input int k, output word_t w);
    for (int b = 0; b < 4; b++) begin
      rd_addr = 6'(k * 4 + b);
      #1 w[8*b +: 8] = rdd;
    end
  endtask

  task automatic load_rfc(input word_t ctr);
    word_t v [16] = '{SIGMA_0, SIGMA_1, SIGMA_2, SIGMA_3,
                      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                      32'h0, 32'h09000000, 32'h4a000000, 32'h00000000};
    v[12] = ctr;
    for (int k = 0; k < 16; k++) write_word(k, v[k]);
  endtask

  // guard>0: inject wr_en to byte 0 plus start in that busy cycle; wr_same: write with start
  task automatic run_block(input int guard, input bit wr_same);
    int     dr, cyc, nbusy;
    bit     seen;
    state_t e;
    word_t  w;
    dr = sel ? 4 : 10;
    exp_q.push_back(model(sh[sel], dr, !sel));
    sh[sel][12] += 32'd1;
    @(negedge clk);
    start = 1'b1;
    if (wr_same) begin wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'hAA; end
    nbusy = 0; seen = 1'b0; cyc = 0;
    for (int i = 1; i < 300 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      cyc = i;
      if (done_s) seen = 1'b1;
      else begin
        if (busy_s) nbusy++;
        if (i == guard) begin start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h55; end
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("done_cycle", cyc, 8 * dr + 2);
    check("busy_cycles", nbusy, 8 * dr + 1);
    e = exp_q.pop_front();
    for (int k = 0; k < 16; k++) begin
      read_word(k, w);
      check($sformatf("word%0d", k), w, e[k]);
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done_s}, 32'd0);
  endtask

  task automatic check_rfc();
    word_t w;
    word_t r [4] = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3};
    for (int k = 0; k < 4; k++) begin
      read_word(k, w);
      check($sformatf("rfc_word%0d", k), w, r[k]);
    end
  endtask

  initial begin
    word_t w;
    int    nz;
    sh[0] = '0; sh[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy1}, 32'd0);
    check("reset_done", {31'd0, done1}, 32'd0);
    read_word(0, w);
    check("reset_work0", w, 32'd0);

    check("qr_a", qa_o, 32'hea2a92f4);
    check("qr_b", qb_o, 32'hcb1cf8ce);
    check("qr_c", qc_o, 32'h4581472e);
    check("qr_d", qd_o, 32'h5881c4bb);

    sel = 1'b0;
    load_rfc(32'd1);
    run_block(0, 1'b0);
    check_rfc();
    run_block(0, 1'b0);                // counter auto-incremented to 2
    write_word(12, 32'hffffffff);
    run_block(0, 1'b0);
    run_block(0, 1'b0);                // counter wrapped to 0, word 13 untouched
    run_block(40, 1'b0);               // busy-time write/start ignored
    run_block(0, 1'b1);                // coincident write dropped

    // reset abandons a block in flight
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sh[0] = '0; sh[1] = '0;
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    nz = 0;
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1 if (rdd != 8'h00) nz++;
    end
    check("rst_zero_bytes", nz, 0);
    load_rfc(32'd1);
    run_block(0, 1'b0);
    check_rfc();

    sel = 1'b1;
    load_rfc(32'd1);
    run_block(0, 1'b0);
    run_block(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
